// File: rtl/sram_pkg.sv
// Shared SRAM bus constants and the read-pipeline entry type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sram_pkg;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;
    localparam int LANE_W      = 8;

    // Lane index into the 16-bit word: lane n covers bits [n*8 +: 8].
    localparam int UB_LANE = 1;
    localparam int LB_LANE = 0;

    // One read in flight. ub/lb are the active-low lane enables as they
    // were on the bus at sample time, so the drive decision follows the
    // request that produced the data rather than the current bus state.
    typedef struct packed {
        logic                   valid;
        logic [SRAM_DATA_W-1:0] data;
        logic                   ub;
        logic                   lb;
    } rd_entry_t;

endpackage

// File: rtl/sram_read_pipe.sv
// Fixed-depth shift register carrying read responses toward the DQ drivers.
// Latency: DEPTH clock edges from sample to oldest.
// Backpressure: none; shifts every cycle, async clear drops everything in flight.
module sram_read_pipe
    import sram_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  rd_entry_t sample,
    output rd_entry_t oldest
);

    rd_entry_t stage [DEPTH];

    // Shift one stage per edge; reset empties every stage at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= sample;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign oldest = stage[DEPTH-1];

endmodule

// File: rtl/sram_responder.sv
// Behavioural-equivalent SRAM chip for the CPU's external 16-bit SRAM bus.
// Latency: read data drives DQ READ_LATENCY edges after sample (sample edge is edge 1).
// Backpressure: none; one access accepted every cycle, reads fully pipelined.
// Optional feature macro: SRAM_RESPONDER_BYTE_LANE_EN (per-lane write and drive
// gating by UB_N/LB_N); when undefined the lane enables are ignored.
module sram_responder
    import sram_pkg::*;
#(
    parameter int ADDR_W       = SRAM_ADDR_W,
    parameter int DATA_W       = SRAM_DATA_W,
    parameter int MEM_DEPTH    = 1024,
    parameter int READ_LATENCY = 2,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [DATA_W-1:0] SRAM_DQ,
    input  logic              SRAM_WE_N,
    input  logic              SRAM_UB_N,
    input  logic              SRAM_LB_N,
    input  logic              SRAM_CE_N,
    input  logic              SRAM_OE_N,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic [CNT_W-1:0]  wr_cnt
);

    localparam int IDX_W = $clog2(MEM_DEPTH);

    // Configuration sanity: these stop elaboration rather than build a
    // responder that silently misbehaves.
    if ((READ_LATENCY < 1) || (READ_LATENCY > 8)) begin : g_bad_latency
        $error("sram_responder: READ_LATENCY=%0d outside 1..8", READ_LATENCY);
    end
    if ((MEM_DEPTH < 2) || ((MEM_DEPTH & (MEM_DEPTH - 1)) != 0) || (IDX_W > ADDR_W)) begin : g_bad_depth
        $error("sram_responder: MEM_DEPTH=%0d must be a power of two within the address space", MEM_DEPTH);
    end
    if (DATA_W != SRAM_DATA_W) begin : g_bad_width
        $error("sram_responder: DATA_W must be %0d", SRAM_DATA_W);
    end

    logic [DATA_W-1:0] mem [MEM_DEPTH];
    logic [IDX_W-1:0]  idx;
    logic              wr_cycle;
    logic              rd_sample;
    logic [1:0]        lane_wr;
    logic              wr_commit;
    rd_entry_t         head;
    rd_entry_t         tail;
    logic              drive_en;
    logic              ub_drv;
    logic              lb_drv;

    // Upper address bits deliberately ignored: the array aliases.
    wire unused_addr = ^SRAM_ADDR;

    assign idx       = SRAM_ADDR[IDX_W-1:0];
    assign wr_cycle  = ~SRAM_CE_N & ~SRAM_WE_N;
    assign rd_sample = ~SRAM_CE_N &  SRAM_WE_N;

`ifdef SRAM_RESPONDER_BYTE_LANE_EN
    assign lane_wr[UB_LANE] = wr_cycle & ~SRAM_UB_N;
    assign lane_wr[LB_LANE] = wr_cycle & ~SRAM_LB_N;
`else
    assign lane_wr = {2{wr_cycle}};
`endif
    assign wr_commit = |lane_wr;

    // Lane-granular array update; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (lane_wr[UB_LANE]) begin
            mem[idx][UB_LANE*LANE_W +: LANE_W] <= SRAM_DQ[UB_LANE*LANE_W +: LANE_W];
        end
        if (lane_wr[LB_LANE]) begin
            mem[idx][LB_LANE*LANE_W +: LANE_W] <= SRAM_DQ[LB_LANE*LANE_W +: LANE_W];
        end
    end

    // Data is captured at sample time, so later writes cannot disturb a
    // read already in the pipeline.
    always_comb begin
        head       = '0;
        head.valid = rd_sample;
        head.data  = mem[idx];
        head.ub    = SRAM_UB_N;
        head.lb    = SRAM_LB_N;
    end

    sram_read_pipe #(
        .DEPTH (READ_LATENCY)
    ) u_read_pipe (
        .clk    (clk),
        .rst_n  (rst),
        .sample (head),
        .oldest (tail)
    );

    // Enables follow the live control pins so OE_N/CE_N/WE_N release the
    // bus within the same cycle; WE_N low always keeps us off the bus.
    assign drive_en = tail.valid & ~SRAM_CE_N & ~SRAM_OE_N & SRAM_WE_N;

`ifdef SRAM_RESPONDER_BYTE_LANE_EN
    assign ub_drv = drive_en & ~tail.ub;
    assign lb_drv = drive_en & ~tail.lb;
`else
    assign ub_drv = drive_en;
    assign lb_drv = drive_en;
    wire unused_lanes = tail.ub ^ tail.lb;
`endif

    assign SRAM_DQ[UB_LANE*LANE_W +: LANE_W] = ub_drv ? tail.data[UB_LANE*LANE_W +: LANE_W] : {LANE_W{1'bz}};
    assign SRAM_DQ[LB_LANE*LANE_W +: LANE_W] = lb_drv ? tail.data[LB_LANE*LANE_W +: LANE_W] : {LANE_W{1'bz}};

    // Saturating access counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else begin
            if (rd_sample && (rd_cnt != {CNT_W{1'b1}})) begin
                rd_cnt <= rd_cnt + 1'b1;
            end
            if (wr_commit && (wr_cnt != {CNT_W{1'b1}})) begin
                wr_cnt <= wr_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder: directed bus scenarios plus random traffic
// compared every cycle against a word-array + sample-history model.
// Build with or without SRAM_RESPONDER_BYTE_LANE_EN; expectations follow the build.
module tb_sram_responder;

    localparam int LAT   = 2;
    localparam int CNT_W = 6;
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef struct {
        bit          v;
        logic [15:0] d;
        bit          ub;
        bit          lb;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [17:0] addr;
    logic        we_n, ub_n, lb_n, ce_n, oe_n;
    logic        tb_drv;
    logic [15:0] wdat;
    wire  [15:0] dq;
    logic [CNT_W-1:0] rd_cnt, wr_cnt;

    assign dq = tb_drv ? wdat : 16'hzzzz;

    sram_responder #(
        .MEM_DEPTH    (1024),
        .READ_LATENCY (LAT),
        .CNT_W        (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .SRAM_ADDR (addr),
        .SRAM_DQ   (dq),
        .SRAM_WE_N (we_n),
        .SRAM_UB_N (ub_n),
        .SRAM_LB_N (lb_n),
        .SRAM_CE_N (ce_n),
        .SRAM_OE_N (oe_n),
        .rd_cnt    (rd_cnt),
        .wr_cnt    (wr_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: word array, per-edge record of what was sampled, counters.
    logic [15:0] mmem [1024];
    exp_t        hist [16];
    exp_t        e_new;
    exp_t        ent;
    int          edge_n = 0;
    int          rd_m = 0;
    int          wr_m = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // An undriven lane reads as Z on four-state simulators and as 0 on two-state ones.
    function automatic bit released(input logic [7:0] v);
        return $isunknown(v) || (v == 8'h00);
    endfunction

    task automatic chk_rel(input string nm, input logic [7:0] act);
        n_cmp++;
        if (!released(act)) begin
            n_err++;
            $display("FAIL %s: got %h expected released (Z)", nm, act);
        end
    endtask

    task automatic lane_chk(input string nm, input logic [7:0] act, input bit drv,
                            input logic [7:0] dv, input bit ext, input logic [7:0] ev);
        if (drv || ext) chk(nm, {24'd0, act}, {24'd0, (drv ? dv : ev)});
        else            chk_rel(nm, act);
    endtask

    // Model update: at each edge record the read sample (pre-edge array content)
    // and apply any write; reset forgets everything but the array.
    initial begin
        for (int i = 0; i < 16; i++) hist[i].v = 1'b0;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                for (int i = 0; i < 16; i++) hist[i].v = 1'b0;
                rd_m = 0;
                wr_m = 0;
            end else begin
                e_new.v = 1'b0; e_new.d = '0; e_new.ub = 1'b1; e_new.lb = 1'b1;
                edge_n++;
                if (!ce_n && we_n) begin
                    e_new.v  = 1'b1;
                    e_new.d  = mmem[addr[9:0]];
                    e_new.ub = ub_n;
                    e_new.lb = lb_n;
                    if (rd_m < CMAX) rd_m++;
                end
                if (!ce_n && !we_n) begin
                    bit uw, lw;
`ifdef SRAM_RESPONDER_BYTE_LANE_EN
                    uw = !ub_n; lw = !lb_n;
`else
                    uw = 1'b1;  lw = 1'b1;
`endif
                    if (uw) mmem[addr[9:0]][15:8] = wdat[15:8];
                    if (lw) mmem[addr[9:0]][7:0]  = wdat[7:0];
                    if ((uw || lw) && (wr_m < CMAX)) wr_m++;
                end
                hist[edge_n & 15] = e_new;
            end
        end
    end

    // Every cycle: outputs after edge E carry the sample taken at edge E-LAT+1.
    initial begin
        forever begin
            bit drv, udrv, ldrv;
            @(negedge clk);
            #2;
            ent = hist[(edge_n - LAT + 1) & 15];
            drv = ent.v && !ce_n && !oe_n && we_n;
`ifdef SRAM_RESPONDER_BYTE_LANE_EN
            udrv = drv && !ent.ub;
            ldrv = drv && !ent.lb;
`else
            udrv = drv;
            ldrv = drv;
`endif
            lane_chk("cyc_dq_hi", dq[15:8], udrv, ent.d[15:8], tb_drv, wdat[15:8]);
            lane_chk("cyc_dq_lo", dq[7:0],  ldrv, ent.d[7:0],  tb_drv, wdat[7:0]);
            chk("cyc_rd_cnt", {26'd0, rd_cnt}, rd_m);
            chk("cyc_wr_cnt", {26'd0, wr_cnt}, wr_m);
        end
    end

    // One bus cycle: inputs change at the falling edge, return just after the
    // rising edge that sampled them.
    task automatic step(input logic c, input logic w, input logic o, input logic u,
                        input logic l, input logic [17:0] a, input logic [15:0] d);
        @(negedge clk);
        ce_n = c; we_n = w; oe_n = o; ub_n = u; lb_n = l; addr = a; wdat = d;
        tb_drv = !w;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1; ub_n = 1'b0; lb_n = 1'b0;
        addr = '0; wdat = '0; tb_drv = 1'b0;

        // Reset then idle
        #10;
        chk("reset_rd_cnt", {26'd0, rd_cnt}, 0);
        chk("reset_wr_cnt", {26'd0, wr_cnt}, 0);
        chk_rel("reset_dq_hi", dq[15:8]);
        chk_rel("reset_dq_lo", dq[7:0]);
        #2 rst = 1'b1;
        step(1, 1, 1, 0, 0, 18'd0, 16'h0);

        // Full-word write then read
        step(0, 0, 1, 0, 0, 18'd5, 16'hBEEF);
        step(0, 1, 0, 0, 0, 18'd5, 16'h0);
        chk("t2_rd_cnt", {26'd0, rd_cnt}, 1);
        chk("t2_wr_cnt", {26'd0, wr_cnt}, 1);
        chk("t2_model_rd", rd_m, 1);
        chk_rel("t2_early_hi", dq[15:8]);
        chk_rel("t2_early_lo", dq[7:0]);
        step(0, 1, 0, 0, 0, 18'd5, 16'h0);
        chk("t2_dq", {16'd0, dq}, 32'h0000BEEF);

        // Byte lanes
        step(0, 0, 1, 0, 0, 18'd7, 16'h1234);
        step(0, 0, 1, 0, 1, 18'd7, 16'hAB00);
        step(0, 1, 0, 0, 0, 18'd7, 16'h0);
        step(0, 1, 0, 1, 0, 18'd7, 16'h0);
`ifdef SRAM_RESPONDER_BYTE_LANE_EN
        chk("t3_word", {16'd0, dq}, 32'h0000AB34);
        step(0, 1, 0, 0, 0, 18'd7, 16'h0);
        chk("t3_lo", {24'd0, dq[7:0]}, 32'h34);
        chk_rel("t3_hi", dq[15:8]);
`else
        chk("t3_word", {16'd0, dq}, 32'h0000AB00);
        step(0, 1, 0, 0, 0, 18'd7, 16'h0);
        chk("t3_word_ub_off", {16'd0, dq}, 32'h0000AB00);
`endif

        // Pipelined back-to-back reads
        for (int k = 0; k < 4; k++) step(0, 0, 1, 0, 0, 18'(k), 16'(16'h0010 + k));
        for (int k = 0; k < 5; k++) begin
            step(0, 1, 0, 0, 0, 18'((k < 4) ? k : 3), 16'h0);
            if (k > 0) chk("t4_dq", {16'd0, dq}, 32'h0010 + 32'(k - 1));
        end

        // Aliasing
        step(0, 0, 1, 0, 0, 18'h00400, 16'h5555);
        step(0, 1, 0, 0, 0, 18'h00000, 16'h0);
        step(0, 1, 0, 0, 0, 18'h00000, 16'h0);
        chk("t5_alias", {16'd0, dq}, 32'h00005555);

        // Reset during a read
        step(0, 1, 0, 0, 0, 18'd5, 16'h0);
        step(0, 1, 0, 0, 0, 18'd5, 16'h0);
        chk("t6_pre", {16'd0, dq}, 32'h0000BEEF);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_rel("t6_rst_hi", dq[15:8]);
        chk_rel("t6_rst_lo", dq[7:0]);
        chk("t6_rst_rd_cnt", {26'd0, rd_cnt}, 0);
        ce_n = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        step(0, 1, 0, 0, 0, 18'd5, 16'h0);
        chk_rel("t6_late_hi", dq[15:8]);
        chk_rel("t6_late_lo", dq[7:0]);
        chk("t6_rd_cnt", {26'd0, rd_cnt}, 1);
        step(0, 1, 0, 0, 0, 18'd5, 16'h0);
        chk("t6_kept", {16'd0, dq}, 32'h0000BEEF);

        // Random traffic over a small, fully initialised, aliased window
        for (int k = 0; k < 16; k++) step(0, 0, 1, 0, 0, 18'(k), 16'($urandom));
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                @(negedge clk);
                rst = 1'b0;
                repeat (2) @(negedge clk);
                rst = 1'b1;
            end
            step(($urandom % 5) == 0, ($urandom % 3) != 0, ($urandom % 4) == 0,
                 ($urandom % 4) == 0, ($urandom % 4) == 0,
                 18'(($urandom % 16) | (($urandom % 2) << 10) | (($urandom % 2) << 17)),
                 16'($urandom));
        end

        step(1, 1, 1, 0, 0, 18'd0, 16'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Synthesizable responder for the external 16-bit SRAM bus that the CPU's memory stage drives as initiator.
- Emulates the physical SRAM chip: byte-lane writes, read data returned after a fixed pipeline latency, per-lane tri-state DQ drive.
- Sits opposite the CPU SRAM interface in simulation and FPGA bring-up benches; also usable as an on-chip stand-in when the board SRAM is absent.

Parameters:
- ADDR_W, 18, width of SRAM_ADDR.
- DATA_W, 16, width of SRAM_DQ; fixed at 16, two 8-bit lanes.
- MEM_DEPTH, 1024, number of stored words; power of two, at most 2**ADDR_W.
- READ_LATENCY, 2, clock edges from read-address sample to DQ drive; legal range 1..8.
- CNT_W, 16, width of the access counters.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- SRAM_ADDR  in  ADDR_W  word address.
- SRAM_DQ  inout  DATA_W  bidirectional data bus.
- SRAM_WE_N  in  1  write enable, active-low.
- SRAM_UB_N  in  1  upper byte lane [15:8] enable, active-low.
- SRAM_LB_N  in  1  lower byte lane [7:0] enable, active-low.
- SRAM_CE_N  in  1  chip enable, active-low.
- SRAM_OE_N  in  1  output enable, active-low.
- rd_cnt  out  CNT_W  number of read samples accepted; saturating.
- wr_cnt  out  CNT_W  number of writes committed; saturating.

Behaviour:
- Index: only SRAM_ADDR[log2(MEM_DEPTH)-1:0] is used; higher bits are ignored, so addresses alias.
- Write cycle:
  - Condition: CE_N=0 and WE_N=0 at a rising edge.
  - Each enabled lane of mem[idx] is loaded from SRAM_DQ at that edge.
  - If both lanes are disabled, nothing is written and wr_cnt does not increment.
  - The responder never drives DQ while WE_N=0.
- Read sample:
  - Condition: CE_N=0 and WE_N=1 at a rising edge.
  - The pipeline is loaded with {valid=1, data=mem[idx], ub, lb}. The data is the array content before the edge.
  - Any other cycle loads {valid=0}.
- Pipeline: READ_LATENCY stages shift every cycle. The output stage holds valid_o, data_o, ub_o and lb_o.
- DQ drive:
  - Upper lane is driven with data_o[15:8] when valid_o=1, ub_o=0, CE_N=0, OE_N=0 and WE_N=1. Otherwise it is Z.
  - Lower lane uses the same rule with lb_o.
  - The drive enables are combinational on the current CE_N, OE_N and WE_N, so deasserting OE_N releases the bus in the same cycle.
- Back-to-back reads: one read is accepted per cycle, fully pipelined. The address may change every cycle.
- Read after write: a read sampled on the edge after a write to the same idx returns the new data.
- Write during an in-flight read: the in-flight data is not modified, because data was captured at sample time.
- Counters:
  - rd_cnt increments on each read sample.
  - wr_cnt increments on each write with at least one lane enabled.
  - Both saturate at all-ones.
- Reset (rst=0, asynchronous):
  - All pipeline valid bits cleared, DQ released to Z immediately, rd_cnt=0, wr_cnt=0.
  - Memory contents are not cleared and survive reset.
  - Reads in flight at reset are lost.
  - After rst deasserts, the first possible drive occurs READ_LATENCY edges after the first read sample.
- An illegal READ_LATENCY halts elaboration with an error.

Optional Feature:
- Macro: SRAM_RESPONDER_BYTE_LANE_EN.
- Defined: UB_N and LB_N gate writes and DQ drive per lane, as described above.
- Undefined:
  - UB_N and LB_N are ignored.
  - Every write updates the full 16-bit word.
  - Both lanes drive under the shared drive condition.
  - wr_cnt counts every write cycle.

Decomposition:
- Shared package sram_pkg:
  - SRAM_ADDR_W=18 and SRAM_DATA_W=16.
  - Lane index constants UB_LANE and LB_LANE.
  - Read-pipeline entry typedef {valid, data, ub, lb}.
- One sub-module, sram_read_pipe: a parameterized READ_LATENCY shift register of pipeline entries with asynchronous active-low clear.

Test Plan:
1. Reset then idle: rst=0 for 10 ns, then CE_N=1 -> DQ=Z, rd_cnt=0, wr_cnt=0.
2. Full-word write then read, READ_LATENCY=2:
   - Stimulus: write 0xBEEF to addr 5, then read addr 5 with OE_N=0.
   - Response: DQ=0xBEEF exactly 2 edges after the read sample; wr_cnt=1, rd_cnt=1.
3. Byte lanes (macro defined):
   - Stimulus: write 0x1234 to addr 7, then write 0xAB00 with LB_N=1.
   - Response: reading addr 7 gives 0xAB34; a read with UB_N=1 drives DQ[15:8]=Z and DQ[7:0]=0x34.
4. Pipelined reads:
   - Stimulus: after loading addrs 0..3 with 0x0010..0x0013, read addrs 0,1,2,3 on consecutive edges.
   - Response: DQ shows 0x0010, 0x0011, 0x0012, 0x0013 on consecutive cycles.
5. Aliasing with MEM_DEPTH=1024: write 0x5555 to addr 0x00400 -> read addr 0 returns 0x5555.
6. Reset mid-read: issue a read, then assert rst one cycle later -> DQ goes Z immediately, no late drive after release, and memory still holds prior data.
